// File: rtl/rx_pair_framer_pkg.sv
// rx_pair_framer_pkg: shared Viterbi-decoder constants and types used by the received-pair framer.
package rx_pair_framer_pkg;
    localparam int K                = 7;
    localparam int TAIL_LEN_DEFAULT = K - 1;
    localparam int RX_PAIR_W        = 2;
    typedef logic [RX_PAIR_W-1:0] rx_pair_t;
    typedef enum logic {IDLE, RUN} framer_state_e;
endpackage

// File: rtl/rx_pair_outreg.sv
// rx_pair_outreg: registered pair/tag output stage with valid/ready handshake and load-enable.
module rx_pair_outreg
    import rx_pair_framer_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  rx_pair_t pair_d,
    input  logic     start_d,
    input  logic     last_d,
    input  logic     tail_d,
    input  logic     pair_ready_i,
    output logic     load_ok,
    output rx_pair_t rx_pair,
    output logic     pair_valid_o,
    output logic     frame_start_o,
    output logic     frame_last_o,
    output logic     tail_o
);
    assign load_ok = !pair_valid_o || pair_ready_i;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_pair       <= '0;
            pair_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            frame_last_o  <= 1'b0;
            tail_o        <= 1'b0;
        end else if (load) begin
            rx_pair       <= pair_d;
            pair_valid_o  <= 1'b1;
            frame_start_o <= start_d;
            frame_last_o  <= last_d;
            tail_o        <= tail_d;
        end else if (pair_ready_i) begin
            pair_valid_o  <= 1'b0;
        end
endmodule

// File: rtl/rx_pair_framer.sv
// rx_pair_framer: packs serial hard bits into tagged frame pairs; RX_PAIR_FRAME_CNT_EN adds frame_cnt_o.
module rx_pair_framer
    import rx_pair_framer_pkg::*;
#(
    parameter int DATA_LEN = 128,
    parameter int TAIL_LEN = TAIL_LEN_DEFAULT,
    parameter int CNT_W    = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     sync_i,
    input  logic     bit_i,
    input  logic     bit_valid_i,
    output logic     bit_ready_o,
    output rx_pair_t rx_pair,
    output logic     pair_valid_o,
    input  logic     pair_ready_i,
    output logic     frame_start_o,
    output logic     frame_last_o,
    output logic     tail_o,
    output logic     sync_err_o
`ifdef RX_PAIR_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_LEN + TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_IDX = CNT_W'(DATA_LEN);

    framer_state_e    state, state_n;
    logic             phase, phase_n, held, held_n;
    logic             eff_phase, active, wrap, bit_fire, load, load_ok;
    logic [CNT_W-1:0] idx, idx_n, base_idx;

    // A sync realigns before the coincident bit is looked at, so that bit lands in phase 0.
    assign eff_phase   = phase && !sync_i;
    assign base_idx    = sync_i ? '0 : idx;
    assign active      = state == RUN || sync_i;
    assign wrap        = base_idx == LAST_IDX;
    assign bit_ready_o = rst_n && (state == IDLE || !eff_phase || load_ok);
    assign bit_fire    = bit_valid_i && bit_ready_o;
    assign load        = bit_fire && active && eff_phase;

    always_comb begin
        state_n = sync_i ? RUN : state;
        phase_n = eff_phase;
        held_n  = held;
        idx_n   = base_idx;
        if (bit_fire && active) begin
            phase_n = !eff_phase;
            held_n  = eff_phase ? held : bit_i;
            idx_n   = eff_phase ? (wrap ? '0 : base_idx + 1'b1) : base_idx;
            state_n = eff_phase && wrap ? IDLE : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= 1'b0;
            held       <= 1'b0;
            idx        <= '0;
            sync_err_o <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            held       <= held_n;
            idx        <= idx_n;
            sync_err_o <= sync_err_o || (sync_i && state == RUN && (phase || idx != '0));
        end

    rx_pair_outreg u_outreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .pair_d       ({bit_i, held}),
        .start_d      (base_idx == '0),
        .last_d       (wrap),
        .tail_d       (base_idx >= DATA_IDX),
        .pair_ready_i (pair_ready_i),
        .load_ok      (load_ok),
        .rx_pair      (rx_pair),
        .pair_valid_o (pair_valid_o),
        .frame_start_o(frame_start_o),
        .frame_last_o (frame_last_o),
        .tail_o       (tail_o)
    );

`ifdef RX_PAIR_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            frame_cnt_o <= '0;
        else if (pair_valid_o && pair_ready_i && frame_last_o)
            frame_cnt_o <= frame_cnt_o + 16'd1;
`endif
endmodule

// File: tb/tb_rx_pair_framer.sv
// tb_rx_pair_framer: directed bench with a bit-count frame model and per-cycle output compare.
module tb_rx_pair_framer;
    localparam int DL = 4;
    localparam int TL = 2;
    localparam int NP = DL + TL;

    logic clk = 0, rst_n = 0, sync_i = 0, bit_i = 0, bit_valid_i = 0, pair_ready_i = 1;
    logic bit_ready_o, pair_valid_o, frame_start_o, frame_last_o, tail_o, sync_err_o;
    logic [1:0] rx_pair;
`ifdef RX_PAIR_FRAME_CNT_EN
    logic [15:0] frame_cnt_o;
    logic [15:0] m_cnt = '0;
`endif

    int compared = 0, mismatched = 0;
    typedef struct packed {logic [1:0] p; logic s, l, t;} exp_t;
    exp_t q[$];
    logic in_frame = 0, m_err = 0, prev = 0;
    int n = 0;

    rx_pair_framer #(.DATA_LEN(DL), .TAIL_LEN(TL), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_i       (sync_i),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .rx_pair      (rx_pair),
        .pair_valid_o (pair_valid_o),
        .pair_ready_i (pair_ready_i),
        .frame_start_o(frame_start_o),
        .frame_last_o (frame_last_o),
        .tail_o       (tail_o),
        .sync_err_o   (sync_err_o)
`ifdef RX_PAIR_FRAME_CNT_EN
        ,
        .frame_cnt_o  (frame_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame position is just the count of bits accepted since the last sync.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            in_frame = 0;
            m_err = 0;
            n = 0;
`ifdef RX_PAIR_FRAME_CNT_EN
            m_cnt = '0;
`endif
        end else begin
            if (pair_valid_o && pair_ready_i && q.size() != 0) begin
`ifdef RX_PAIR_FRAME_CNT_EN
                if (q[0].l) m_cnt = m_cnt + 16'd1;
`endif
                void'(q.pop_front());
            end
            if (sync_i) begin
                if (in_frame && n != 0) m_err = 1;
                in_frame = 1;
                n = 0;
            end
            if (bit_valid_i && bit_ready_o && in_frame) begin
                if (n % 2 == 1) begin
                    int k;
                    k = n / 2;
                    q.push_back('{p: {bit_i, prev}, s: k == 0, l: k == NP - 1, t: k >= DL});
                    if (k == NP - 1) in_frame = 0;
                end else begin
                    prev = bit_i;
                end
                n++;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        check("pair_valid", pair_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            check("rx_pair", rx_pair, q[0].p);
            check("frame_start", frame_start_o, q[0].s);
            check("frame_last", frame_last_o, q[0].l);
            check("tail", tail_o, q[0].t);
        end
        check("sync_err", sync_err_o, m_err);
        check("bit_ready", bit_ready_o,
              !rst_n ? 1'b0 : (in_frame && n % 2 == 1 && !sync_i) ? (!pair_valid_o || pair_ready_i) : 1'b1);
`ifdef RX_PAIR_FRAME_CNT_EN
        check("frame_cnt", frame_cnt_o, m_cnt);
`endif
    end

    task automatic step(input logic v, input logic b, input logic s, input logic r);
        bit_valid_i = v; bit_i = b; sync_i = s; pair_ready_i = r;
        @(posedge clk);
        #1;
        bit_valid_i = 0; sync_i = 0;
        @(negedge clk);
    endtask

    task automatic stream(input int nb, input logic [15:0] pat, input int hold);
        int k = 0, cyc = 0;
        while (k < nb && cyc < nb + hold + 20) begin
            bit_valid_i = 1; bit_i = pat[k]; sync_i = 0; pair_ready_i = cyc >= hold;
            #4;
            if (bit_ready_o) k++;
            @(negedge clk);
            cyc++;
        end
        bit_valid_i = 0; pair_ready_i = 1;
        if (k < nb) check("stream_timeout", 16'(k), 16'(nb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", pair_valid_o, 0);
        check("rst_pair", rx_pair, 0);
        check("rst_ready", bit_ready_o, 0);
        check("rst_err", sync_err_o, 0);
        rst_n = 1;
        #1 check("idle_ready", bit_ready_o, 1);
        @(negedge clk);

        // Basic packing and full frame: 1,0,1,1 then 0,1,1,0,0,0,1,0.
        step(0, 0, 1, 1);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        check("p0_valid", pair_valid_o, 1);
        check("p0_pair", rx_pair, 2'b01);
        check("p0_start", frame_start_o, 1);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        check("p1_pair", rx_pair, 2'b11);
        check("p1_start", frame_start_o, 0);
        check("p1_tail", tail_o, 0);
        stream(8, 16'h0046, 0);
        check("p5_pair", rx_pair, 2'b01);
        check("p5_last", frame_last_o, 1);
        check("p5_tail", tail_o, 1);
        step(0, 0, 0, 1);
        check("after_last_valid", pair_valid_o, 0);
        stream(4, 16'h000F, 0);
        check("idle_discard", pair_valid_o, 0);

        // Back-pressure: one pair pending, stall five cycles at phase 1.
        step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            bit_valid_i = 1; bit_i = 1; pair_ready_i = 0;
            #4 check("bp_ready", bit_ready_o, 0);
            @(negedge clk);
            check("bp_hold_pair", rx_pair, 2'b11);
            check("bp_hold_valid", pair_valid_o, 1);
        end
        stream(9, 16'h01B3, 0);

        // Mid-frame resync coincident with a bit after three bits.
        step(0, 0, 1, 1);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        step(1, 0, 1, 1);
        check("resync_err", sync_err_o, 1);
        step(1, 1, 0, 1);
        check("resync_pair", rx_pair, 2'b10);
        check("resync_start", frame_start_o, 1);
        stream(10, 16'h02AA, 0);
        step(0, 0, 0, 1);
        check("err_sticky", sync_err_o, 1);
`ifdef RX_PAIR_FRAME_CNT_EN
        check("cnt_three", frame_cnt_o, 16'd3);
`endif

        // Asynchronous reset with a pair pending.
        step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        check("pre_rst_valid", pair_valid_o, 1);
        #3 rst_n = 0;
        #1;
        check("arst_valid", pair_valid_o, 0);
        check("arst_pair", rx_pair, 0);
        check("arst_start", frame_start_o, 0);
        check("arst_err", sync_err_o, 0);
        check("arst_ready", bit_ready_o, 0);
        @(negedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        stream(4, 16'h000F, 0);
        check("no_stale_pair", pair_valid_o, 0);

`ifdef RX_PAIR_FRAME_CNT_EN
        #1 force dut.frame_cnt_o = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #2 release dut.frame_cnt_o;
        @(negedge clk);
        step(0, 0, 1, 1);
        stream(12, 16'h0123, 0);
        step(0, 0, 0, 1);
        check("cnt_wrap", frame_cnt_o, 16'd0);
`endif

        step(0, 0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
